// File: rtl/key_typematic_fifo.sv
// Keystroke buffer with typematic auto-repeat, feeding the text editor.
// Latency: a character pushed into an empty, idle FIFO strobes NewKey one cycle later.
// Backpressure: none upstream; pushes into a full FIFO are dropped and flagged on overflow.
//
// Ports:
//   sys_clk    clk50 domain clock
//   reset      synchronous, active-high reset
//   key_code   synchronised USB keycode, 0 = no key held
//   new_key    1-cycle strobe, ascii_in valid
//   ascii_in   decoded character, 0 = non-printable (ignored)
//   NewKey     1-cycle strobe to the editor, at least GAP_CYC low cycles between strobes
//   Ascii      character, valid with NewKey and held until the next strobe
//   fifo_level current FIFO occupancy
//   overflow   sticky flag: a push was dropped because the FIFO was full
//   repeating  high while auto-repeat is running
module key_typematic_fifo #(
  parameter int DELAY_CYC = 25_000_000,
  parameter int RATE_CYC  = 2_500_000,
  parameter int DEPTH     = 8,
  parameter int GAP_CYC   = 16
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [7:0]               key_code,
  input  logic                     new_key,
  input  logic [7:0]               ascii_in,
  output logic                     NewKey,
  output logic [7:0]               Ascii,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     repeating
);

  localparam int MAXC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int GW   = $clog2(GAP_CYC + 1);

  localparam logic [CW-1:0] DLY_LAST  = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(RATE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      held_code_q, held_code_d;
  logic [7:0]      held_ascii_q, held_ascii_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            push;
  logic [7:0]      push_dat;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [GW-1:0]   gap_cnt;
  logic            pop, full, push_ok;

  // ---------------------------------------------------------------
  // Repeat FSM
  // ---------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      held_code_q  <= 8'd0;
      held_ascii_q <= 8'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      held_code_q  <= held_code_d;
      held_ascii_q <= held_ascii_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    held_code_d  = held_code_q;
    held_ascii_d = held_ascii_q;
    cnt_d        = cnt_q;
    push         = 1'b0;
    push_dat     = held_ascii_q;

    // A fresh printable keystroke wins over cancel and expiry in the same cycle.
    if (new_key && (ascii_in != 8'd0)) begin
      push         = 1'b1;
      push_dat     = ascii_in;
      held_code_d  = key_code;
      held_ascii_d = ascii_in;
      cnt_d        = '0;
      state_d      = S_DELAY;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
        end
        S_DELAY: begin
          if (key_code != held_code_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DLY_LAST) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_REPEAT: begin
          if (key_code != held_code_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == RATE_LAST) begin
            push  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign repeating = (state_q == S_REPEAT);

  // ---------------------------------------------------------------
  // FIFO and paced output
  // ---------------------------------------------------------------
  // pop looks only at registered occupancy, so an entry written this cycle
  // cannot leave until the next one.
  assign pop     = (fifo_level != '0) && (gap_cnt == '0);
  assign full    = (fifo_level == LW'(DEPTH));
  assign push_ok = push && (!full || pop);

  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      gap_cnt    <= '0;
      NewKey     <= 1'b0;
      Ascii      <= 8'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end

      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase

      if (pop) begin
        NewKey  <= 1'b1;
        Ascii   <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
        gap_cnt <= GW'(GAP_CYC);
      end else begin
        NewKey <= 1'b0;
        if (gap_cnt != '0) begin
          gap_cnt <= gap_cnt - GW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_key_typematic_fifo.sv
// Randomised and scenario-driven bench for key_typematic_fifo with a scoreboard.
// Reference model works in absolute edge numbers and a character queue.
// Monitor on the falling edge consumes expected strobes and checks status outputs.
module tb_key_typematic_fifo;

  localparam int DELAY = 20;
  localparam int RATE  = 5;
  localparam int DEPTH = 4;
  localparam int GAP   = 3;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  key_code = 8'd0;
  logic        new_key  = 1'b0;
  logic [7:0]  ascii_in = 8'd0;
  logic        NewKey;
  logic [7:0]  Ascii;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        overflow;
  logic        repeating;

  key_typematic_fifo #(
    .DELAY_CYC(DELAY),
    .RATE_CYC (RATE),
    .DEPTH    (DEPTH),
    .GAP_CYC  (GAP)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .key_code  (key_code),
    .new_key   (new_key),
    .ascii_in  (ascii_in),
    .NewKey    (NewKey),
    .Ascii     (Ascii),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .repeating (repeating)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] ch;
    int         at_edge;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq[$];
  int         ecnt = 0;
  bit         m_active = 0;
  int         m_start = 0;
  logic [7:0] m_code = 8'd0;
  logic [7:0] m_asc = 8'd0;
  bit         m_ovf = 0;
  int         m_next_pop = 0;
  logic [7:0] m_last = 8'd0;
  bit         m_rep = 0;
  bit         m_push;
  logic [7:0] m_pd;
  int         m_d;
  bit         chk_en = 0;

  always @(posedge sys_clk) begin
    ecnt++;
    if (reset) begin
      mq.delete();
      m_active   = 0;
      m_ovf      = 0;
      m_next_pop = 0;
      m_last     = 8'd0;
      m_rep      = 0;
    end else begin
      m_push = 0;
      m_pd   = 8'd0;
      if (new_key && ascii_in != 8'd0) begin
        m_push   = 1;
        m_pd     = ascii_in;
        m_active = 1;
        m_start  = ecnt;
        m_code   = key_code;
        m_asc    = ascii_in;
      end else if (m_active && key_code != m_code) begin
        m_active = 0;
      end else if (m_active) begin
        // Repeats land DELAY edges after the keystroke, then every RATE edges.
        m_d = ecnt - m_start;
        if (m_d == DELAY || (m_d > DELAY && ((m_d - DELAY) % RATE) == 0)) begin
          m_push = 1;
          m_pd   = m_asc;
        end
      end
      // Pop decision uses the queue as it stood before this edge's push.
      if (mq.size() != 0 && ecnt >= m_next_pop) begin
        m_last = mq.pop_front();
        sb.push_back('{m_last, ecnt});
        m_next_pop = ecnt + GAP + 1;
      end
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(m_pd);
        else m_ovf = 1;
      end
      m_rep = m_active && ((ecnt - m_start) >= DELAY);
    end
  end

  // ---------------- monitor ----------------
  exp_t e;
  always @(negedge sys_clk) begin
    if (chk_en) begin
      if (NewKey) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL strobe_unexpected: NewKey with Ascii=%h at edge %0d, none expected", Ascii, ecnt);
        end else begin
          e = sb.pop_front();
          if (Ascii !== e.ch || ecnt != e.at_edge) begin
            n_bad++;
            $display("FAIL strobe: got Ascii=%h at edge %0d, expected %h at edge %0d",
                     Ascii, ecnt, e.ch, e.at_edge);
          end
        end
      end else if (sb.size() != 0 && sb[0].at_edge <= ecnt) begin
        n_cmp++;
        n_bad++;
        $display("FAIL strobe_missing: no NewKey at edge %0d, expected Ascii=%h", ecnt, sb[0].ch);
        void'(sb.pop_front());
      end

      n_cmp++;
      if (int'(fifo_level) != mq.size() || overflow !== m_ovf ||
          repeating !== m_rep || Ascii !== m_last) begin
        n_bad++;
        $display("FAIL status @edge %0d: level=%0d ovf=%b rep=%b ascii=%h, expected level=%0d ovf=%b rep=%b ascii=%h",
                 ecnt, fifo_level, overflow, repeating, Ascii, mq.size(), m_ovf, m_rep, m_last);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic [7:0] kc, input bit nk, input logic [7:0] a);
    @(negedge sys_clk);
    reset    = 1'b0;
    key_code = kc;
    new_key  = nk;
    ascii_in = a;
  endtask

  task automatic idle(input int n, input logic [7:0] kc);
    for (int i = 0; i < n; i++) tick(kc, 1'b0, 8'd0);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge sys_clk);
    reset   = 1'b1;
    new_key = 1'b0;
    for (int i = 1; i < n; i++) @(negedge sys_clk);
  endtask

  int r;
  int w;
  logic [7:0] kc_r;

  initial begin
    @(posedge sys_clk);
    chk_en = 1;
    pulse_reset(3);

    // Tap
    tick(8'h04, 1'b1, 8'h61); idle(2, 8'h04); idle(30, 8'h00);
    // Hold through several repeats
    tick(8'h04, 1'b1, 8'h61); idle(37, 8'h04); idle(30, 8'h00);
    // Rollover to a second key during repeat
    tick(8'h04, 1'b1, 8'h61); idle(27, 8'h04);
    tick(8'h05, 1'b1, 8'h62); idle(30, 8'h05); idle(30, 8'h00);
    // Burst overflowing the FIFO
    for (int i = 0; i < 8; i++) tick(8'h10 + 8'(i), 1'b1, 8'h31 + 8'(i));
    idle(40, 8'h00);
    // Reset while repeating with a character queued
    tick(8'h04, 1'b1, 8'h61); idle(DELAY, 8'h04);
    pulse_reset(1);
    idle(40, 8'h04); idle(10, 8'h00);
    // Non-printable strobe during delay leaves repeat timing alone
    tick(8'h04, 1'b1, 8'h61); idle(8, 8'h04);
    tick(8'h04, 1'b1, 8'h00); idle(30, 8'h04); idle(20, 8'h00);
    // Sticky overflow cleared by reset
    pulse_reset(2);

    // Random traffic over a small keycode set so holds and rollovers collide
    kc_r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        pulse_reset(1 + $urandom_range(0, 1));
      end else if (r < 12) begin
        kc_r = 8'($urandom_range(1, 3));
        tick(kc_r, 1'b1, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(8'h20, 8'h7e)));
      end else if (r < 18) begin
        kc_r = 8'($urandom_range(0, 3));
        tick(kc_r, 1'b0, 8'h00);
      end else begin
        tick(kc_r, 1'b0, 8'h00);
      end
    end

    idle(60, 8'h00);
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge sys_clk);
      w++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected strobes never appeared, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
